// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the receive and transmit paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int DEFAULT_PAYLOAD_BITS = 8;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; latency 2 cycles, no backpressure.
// Resets to RST_VAL so an idle-high line does not look like an edge out of reset.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: deserialises the serial pin into bytes with one-cycle status pulses.
// Latency: pulse 2 + CPB/2 + (PAYLOAD_BITS+1)*CPB + 1 cycles after the start edge; no backpressure.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break,
    output logic                    uart_rx_busy
);

    localparam int CPB  = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int BW   = $clog2(PAYLOAD_BITS + 1);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
    localparam logic [BW-1:0] BITS_M1 = BW'(PAYLOAD_BITS - 1);

    rx_state_t               state;
    logic [CW-1:0]           cyc_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic                    brk_hold;
    logic                    rxd_s;

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_rxd (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (uart_rxd),
        .q       (rxd_s)
    );

    assign uart_rx_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= IDLE;
            cyc_cnt           <= '0;
            bit_cnt           <= '0;
            shreg             <= '0;
            brk_hold          <= 1'b0;
            uart_rx_data      <= '0;
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
        end else begin
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
            // A held-low break line must go high before it can start a new frame.
            if (rxd_s) begin
                brk_hold <= 1'b0;
            end
            if (!uart_rx_en) begin
                state   <= IDLE;
                cyc_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rxd_s && !brk_hold) begin
                            state   <= START;
                            cyc_cnt <= '0;
                            bit_cnt <= '0;
                        end
                    end
                    START: begin
                        if (cyc_cnt == HALF_M1) begin
                            cyc_cnt <= '0;
                            state   <= rxd_s ? IDLE : DATA;
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cyc_cnt == CPB_M1) begin
                            cyc_cnt <= '0;
                            shreg   <= {rxd_s, shreg[PAYLOAD_BITS-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BITS_M1) begin
                                state <= STOP;
                            end
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cyc_cnt == CPB_M1) begin
                            cyc_cnt <= '0;
                            state   <= IDLE;
                            if (rxd_s) begin
                                uart_rx_data  <= shreg;
                                uart_rx_valid <= 1'b1;
                            end else if (shreg == '0) begin
                                uart_rx_break <= 1'b1;
                                brk_hold      <= 1'b1;
                            end else begin
                                uart_rx_frame_err <= 1'b1;
                            end
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames in, event log compared against a frame-level model.
module tb_uart_rx;

    localparam int CLK_HZ   = 1_000_000;
    localparam int BIT_RATE = 100_000;
    localparam int CPB      = CLK_HZ / BIT_RATE;
    localparam int HALF     = CPB / 2;
    localparam int NB       = 8;
    localparam int LAT      = 2 + HALF + (NB + 1) * CPB + 1;
    localparam int K_VALID  = 0;
    localparam int K_FERR   = 1;
    localparam int K_BRK    = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          uart_rxd = 1'b1;
    logic          uart_rx_en = 1'b1;
    logic [NB-1:0] uart_rx_data;
    logic          uart_rx_valid;
    logic          uart_rx_frame_err;
    logic          uart_rx_break;
    logic          uart_rx_busy;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] d;
    } ev_t;

    ev_t        ev_q[$];
    ev_t        exp_q[$];
    int         cyc = 0;
    int         busy_cnt = 0;
    int         multi_cnt = 0;
    int         nchk = 0;
    int         nerr = 0;
    logic [7:0] exp_data = 8'h00;

    uart_rx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(NB)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .uart_rxd          (uart_rxd),
        .uart_rx_en        (uart_rx_en),
        .uart_rx_data      (uart_rx_data),
        .uart_rx_valid     (uart_rx_valid),
        .uart_rx_frame_err (uart_rx_frame_err),
        .uart_rx_break     (uart_rx_break),
        .uart_rx_busy      (uart_rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic ev_t mk_ev(input int c, input int k, input logic [7:0] d);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.d    = d;
        return e;
    endfunction

    // Frame-level reference: what a receiver must report for a given payload and stop bit.
    function automatic int frame_kind(input logic [7:0] p, input bit stop);
        if (stop) return K_VALID;
        if (p == 8'h00) return K_BRK;
        return K_FERR;
    endfunction

    always @(negedge clk) begin
        if (int'(uart_rx_valid) + int'(uart_rx_frame_err) + int'(uart_rx_break) > 1) multi_cnt++;
        if (uart_rx_valid)     ev_q.push_back(mk_ev(cyc, K_VALID, uart_rx_data));
        if (uart_rx_frame_err) ev_q.push_back(mk_ev(cyc, K_FERR, uart_rx_data));
        if (uart_rx_break)     ev_q.push_back(mk_ev(cyc, K_BRK, uart_rx_data));
        if (uart_rx_busy)      busy_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #1 uart_rxd = b;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] p, input bit stop, output int fall);
        @(posedge clk);
        #1 uart_rxd = 1'b0;
        fall = cyc;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < NB; i++) drive_bit(p[i]);
        drive_bit(stop);
        if (!stop) begin
            @(posedge clk);
            #1 uart_rxd = 1'b1;
        end
    endtask

    task automatic clear_log();
        ev_q.delete();
        busy_cnt = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle(3);
        @(negedge clk);
        nchk++; if (uart_rx_data !== 8'h00) begin nerr++; $display("FAIL reset_data got=%h exp=00", uart_rx_data); end
        nchk++; if ({uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_busy} !== 4'b0000) begin
            nerr++; $display("FAIL reset_flags got=%b exp=0000", {uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_busy});
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(5);
    endtask

    task automatic test_good_frame();
        int f;
        clear_log();
        send_frame(8'hA5, 1'b1, f);
        idle(5);
        exp_data = 8'hA5;
        nchk++; if (ev_q.size() !== 1) begin nerr++; $display("FAIL good_count got=%0d exp=1", ev_q.size()); end
        if (ev_q.size() == 1) begin
            nchk++; if (ev_q[0].kind !== K_VALID) begin nerr++; $display("FAIL good_kind got=%0d exp=%0d", ev_q[0].kind, K_VALID); end
            nchk++; if (ev_q[0].d !== 8'hA5) begin nerr++; $display("FAIL good_data got=%h exp=a5", ev_q[0].d); end
            nchk++; if (ev_q[0].cyc !== f + LAT) begin nerr++; $display("FAIL good_latency got=%0d exp=%0d", ev_q[0].cyc - f, LAT); end
        end
        nchk++; if (busy_cnt !== HALF + (NB + 1) * CPB) begin
            nerr++; $display("FAIL good_busy got=%0d exp=%0d", busy_cnt, HALF + (NB + 1) * CPB);
        end
    endtask

    task automatic test_glitch();
        clear_log();
        @(posedge clk);
        #1 uart_rxd = 1'b0;
        idle(2);
        @(posedge clk);
        #1 uart_rxd = 1'b1;
        idle(20);
        nchk++; if (ev_q.size() !== 0) begin nerr++; $display("FAIL glitch_events got=%0d exp=0", ev_q.size()); end
        nchk++; if (busy_cnt !== HALF) begin nerr++; $display("FAIL glitch_busy got=%0d exp=%0d", busy_cnt, HALF); end
        nchk++; if (uart_rx_data !== exp_data) begin nerr++; $display("FAIL glitch_data got=%h exp=%h", uart_rx_data, exp_data); end
    endtask

    task automatic test_frame_err();
        int f;
        clear_log();
        send_frame(8'h3C, 1'b0, f);
        idle(CPB + 5);
        nchk++; if (ev_q.size() !== 1) begin nerr++; $display("FAIL ferr_count got=%0d exp=1", ev_q.size()); end
        if (ev_q.size() == 1) begin
            nchk++; if (ev_q[0].kind !== K_FERR) begin nerr++; $display("FAIL ferr_kind got=%0d exp=%0d", ev_q[0].kind, K_FERR); end
            nchk++; if (ev_q[0].cyc !== f + LAT) begin nerr++; $display("FAIL ferr_latency got=%0d exp=%0d", ev_q[0].cyc - f, LAT); end
        end
        nchk++; if (uart_rx_data !== exp_data) begin nerr++; $display("FAIL ferr_data_kept got=%h exp=%h", uart_rx_data, exp_data); end
        clear_log();
        send_frame(8'h11, 1'b1, f);
        idle(5);
        exp_data = 8'h11;
        nchk++; if (ev_q.size() !== 1 || ev_q[0].kind !== K_VALID) begin nerr++; $display("FAIL ferr_recover got=%0d events exp=1 valid", ev_q.size()); end
        nchk++; if (uart_rx_data !== 8'h11) begin nerr++; $display("FAIL ferr_recover_data got=%h exp=11", uart_rx_data); end
    endtask

    task automatic test_break();
        int f;
        clear_log();
        @(posedge clk);
        #1 uart_rxd = 1'b0;
        f = cyc;
        idle(12 * CPB - 1);
        @(posedge clk);
        #1 uart_rxd = 1'b1;
        idle(30);
        nchk++; if (ev_q.size() !== 1) begin nerr++; $display("FAIL brk_count got=%0d exp=1", ev_q.size()); end
        if (ev_q.size() == 1) begin
            nchk++; if (ev_q[0].kind !== K_BRK) begin nerr++; $display("FAIL brk_kind got=%0d exp=%0d", ev_q[0].kind, K_BRK); end
            nchk++; if (ev_q[0].cyc !== f + LAT) begin nerr++; $display("FAIL brk_latency got=%0d exp=%0d", ev_q[0].cyc - f, LAT); end
        end
        nchk++; if (uart_rx_data !== exp_data) begin nerr++; $display("FAIL brk_data_kept got=%h exp=%h", uart_rx_data, exp_data); end
        clear_log();
        send_frame(8'h5A, 1'b1, f);
        idle(5);
        exp_data = 8'h5A;
        nchk++; if (ev_q.size() !== 1 || uart_rx_data !== 8'h5A) begin
            nerr++; $display("FAIL brk_recover got=%0d events data=%h exp=1 data=5a", ev_q.size(), uart_rx_data);
        end
    endtask

    task automatic test_back_to_back();
        int f0, f1;
        clear_log();
        send_frame(8'h3C, 1'b1, f0);
        send_frame(8'hC3, 1'b1, f1);
        idle(5);
        exp_data = 8'hC3;
        nchk++; if (ev_q.size() !== 2) begin nerr++; $display("FAIL b2b_count got=%0d exp=2", ev_q.size()); end
        if (ev_q.size() == 2) begin
            nchk++; if (ev_q[0].d !== 8'h3C || ev_q[1].d !== 8'hC3) begin
                nerr++; $display("FAIL b2b_data got=%h,%h exp=3c,c3", ev_q[0].d, ev_q[1].d);
            end
            nchk++; if (ev_q[1].cyc - ev_q[0].cyc !== 10 * CPB) begin
                nerr++; $display("FAIL b2b_spacing got=%0d exp=%0d", ev_q[1].cyc - ev_q[0].cyc, 10 * CPB);
            end
        end
    endtask

    task automatic test_abort();
        int f;
        // Synchronous reset during bit 4 of an all-ones frame.
        clear_log();
        fork
            send_frame(8'hFF, 1'b1, f);
            begin
                idle(5 * CPB + 5);
                #1 reset_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                nchk++; if (uart_rx_busy !== 1'b0 || uart_rx_data !== 8'h00) begin
                    nerr++; $display("FAIL rst_mid got busy=%b data=%h exp busy=0 data=00", uart_rx_busy, uart_rx_data);
                end
                @(posedge clk);
                #1 reset_n = 1'b1;
            end
        join
        exp_data = 8'h00;
        idle(10);
        nchk++; if (ev_q.size() !== 0) begin nerr++; $display("FAIL rst_mid_events got=%0d exp=0", ev_q.size()); end
        send_frame(8'h42, 1'b1, f);
        idle(5);
        exp_data = 8'h42;
        nchk++; if (ev_q.size() !== 1 || uart_rx_data !== 8'h42) begin
            nerr++; $display("FAIL rst_recover got=%0d events data=%h exp=1 data=42", ev_q.size(), uart_rx_data);
        end
        // Enable dropped during bit 4: abort without pulse, data retained.
        clear_log();
        fork
            send_frame(8'hFF, 1'b1, f);
            begin
                idle(5 * CPB + 5);
                #1 uart_rx_en = 1'b0;
                @(posedge clk);
                @(negedge clk);
                nchk++; if (uart_rx_busy !== 1'b0 || uart_rx_data !== exp_data) begin
                    nerr++; $display("FAIL en_mid got busy=%b data=%h exp busy=0 data=%h", uart_rx_busy, uart_rx_data, exp_data);
                end
                idle(2);
                #1 uart_rx_en = 1'b1;
            end
        join
        idle(10);
        nchk++; if (ev_q.size() !== 0) begin nerr++; $display("FAIL en_mid_events got=%0d exp=0", ev_q.size()); end
        send_frame(8'h42, 1'b1, f);
        idle(5);
        nchk++; if (ev_q.size() !== 1 || uart_rx_data !== 8'h42) begin
            nerr++; $display("FAIL en_recover got=%0d events data=%h exp=1 data=42", ev_q.size(), uart_rx_data);
        end
    endtask

    task automatic test_random();
        int f;
        logic [7:0] p;
        bit stop;
        clear_log();
        exp_q.delete();
        for (int n = 0; n < 12; n++) begin
            p    = 8'($urandom_range(0, 255));
            if (n == 5) p = 8'h00;
            stop = ($urandom_range(0, 3) != 0);
            send_frame(p, stop, f);
            exp_q.push_back(mk_ev(f + LAT, frame_kind(p, stop), p));
            if (stop) exp_data = p;
            idle(stop ? $urandom_range(0, 3) : CPB + $urandom_range(0, 3));
        end
        idle(10);
        nchk++; if (ev_q.size() !== exp_q.size()) begin nerr++; $display("FAIL rand_count got=%0d exp=%0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            nchk++; if (ev_q[i].kind !== exp_q[i].kind || ev_q[i].cyc !== exp_q[i].cyc) begin
                nerr++; $display("FAIL rand_event[%0d] got kind=%0d cyc=%0d exp kind=%0d cyc=%0d",
                                 i, ev_q[i].kind, ev_q[i].cyc, exp_q[i].kind, exp_q[i].cyc);
            end
            if (exp_q[i].kind == K_VALID) begin
                nchk++; if (ev_q[i].d !== exp_q[i].d) begin nerr++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, ev_q[i].d, exp_q[i].d); end
            end
        end
        nchk++; if (uart_rx_data !== exp_data) begin nerr++; $display("FAIL rand_final_data got=%h exp=%h", uart_rx_data, exp_data); end
        nchk++; if (multi_cnt !== 0) begin nerr++; $display("FAIL pulse_onehot got=%0d overlaps exp=0", multi_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_err();
        test_break();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
